// File: rtl/bp_pkg.sv
// Shared opcodes, branch funct3 encodings and saturating-counter helpers for the branch unit.
// Counter helpers operate on a CTR_MAX_W container; callers zero-extend and truncate to their width.
package bp_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam int CTR_MAX_W = 8;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } fun3_e;

   function automatic logic [CTR_MAX_W-1:0] ctr_inc(input logic [CTR_MAX_W-1:0] ctr, input int w);
      logic [CTR_MAX_W-1:0] max_v;
      max_v = CTR_MAX_W'((64'd1 << w) - 64'd1);
      return (ctr >= max_v) ? ctr : ctr + CTR_MAX_W'(1);
   endfunction

   function automatic logic [CTR_MAX_W-1:0] ctr_dec(input logic [CTR_MAX_W-1:0] ctr);
      return (ctr == '0) ? ctr : ctr - CTR_MAX_W'(1);
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition compare of rs1/rs2 under funct3; purely combinational, no flow control.
// Reserved encodings (010/011) evaluate as not taken.
module branch_cond_eval
   import bp_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [2:0]      fun3,
   output logic            taken
);

   always_comb begin
      taken = 1'b0;
      case (fun3_e'(fun3))
         F3_BEQ:  taken = (rs1 == rs2);
         F3_BNE:  taken = (rs1 != rs2);
         F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
         F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
         F3_BLTU: taken = (rs1 <  rs2);
         F3_BGEU: taken = (rs1 >= rs2);
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal BHT + direct-mapped BTB predicted at IF, resolved at EX; predict/resolve combinational, tables update on the next edge.
// No backpressure: one resolve per cycle when ex_valid. Optional BP_STATS_EN adds registered branch/mispredict counters.
module branch_predict_unit
   import bp_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 64,
   parameter int CTR_W     = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            ex_valid,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [6:0]      ex_opcode,
   input  logic [2:0]      ex_fun3,
   input  logic [XLEN-1:0] ex_rs1,
   input  logic [XLEN-1:0] ex_rs2,
   input  logic [XLEN-1:0] ex_imm,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_tgt,
   output logic            br_taken,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
   ,
   output logic [31:0]     stat_branches,
   output logic [31:0]     stat_mispredicts
`endif
);

   localparam int IDX_W = $clog2(BHT_DEPTH);
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

   logic             btb_valid [BHT_DEPTH];
   logic [TAG_W-1:0] btb_tag   [BHT_DEPTH];
   logic [XLEN-1:0]  btb_tgt   [BHT_DEPTH];
   logic [CTR_W-1:0] ctr_q     [BHT_DEPTH];

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit;

   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[XLEN-1:IDX_W+2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

   // Reads see the registered table, so a same-cycle EX write is not bypassed.
   assign if_hit      = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
   assign pred_taken  = if_hit && ctr_q[if_idx][CTR_W-1];
   assign pred_target = pred_taken ? btb_tgt[if_idx] : if_pc + XLEN'(4);

   logic            is_branch, is_jal, is_jalr, resolve, cond_taken;
   logic [XLEN-1:0] target, ex_pc4;

   assign is_branch = (ex_opcode == OP_BRANCH);
   assign is_jal    = (ex_opcode == OP_JAL);
   assign is_jalr   = (ex_opcode == OP_JALR);
   assign resolve   = ex_valid && (is_branch || is_jal || is_jalr);

   branch_cond_eval #(.XLEN(XLEN)) u_cond (
      .rs1   (ex_rs1),
      .rs2   (ex_rs2),
      .fun3  (ex_fun3),
      .taken (cond_taken)
   );

   assign ex_pc4      = ex_pc + XLEN'(4);
   assign target      = is_jalr ? ((ex_rs1 + ex_imm) & ~XLEN'(1)) : (ex_pc + ex_imm);
   assign br_taken    = resolve && (is_branch ? cond_taken : 1'b1);
   assign mispredict  = ex_valid && ((br_taken != ex_pred_taken) ||
                                     (br_taken && (ex_pred_tgt != target)));
   assign redirect_pc = !ex_valid ? '0 : (br_taken ? target : ex_pc4);
   assign ex_hit      = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) begin
            btb_valid[i] <= 1'b0;
            btb_tag[i]   <= '0;
            btb_tgt[i]   <= '0;
            ctr_q[i]     <= CTR_WNT;
         end
      end else if (resolve) begin
         if (br_taken) begin
            btb_valid[ex_idx] <= 1'b1;
            btb_tag[ex_idx]   <= ex_tag;
            btb_tgt[ex_idx]   <= target;
            // A new owner of the slot starts weakly taken rather than inheriting the alias's history.
            ctr_q[ex_idx]     <= ex_hit ? CTR_W'(ctr_inc(CTR_MAX_W'(ctr_q[ex_idx]), CTR_W)) : CTR_WT;
         end else begin
            ctr_q[ex_idx]     <= CTR_W'(ctr_dec(CTR_MAX_W'(ctr_q[ex_idx])));
         end
      end
   end

`ifdef BP_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (resolve)    stat_branches    <= stat_branches + 32'd1;
         if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed scenarios plus randomized traffic against a table model.
module tb_branch_predict_unit;

   logic        clk, rst_n;
   logic [31:0] if_pc, ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_tgt;
   logic        pred_taken, ex_valid, ex_pred_taken, br_taken, mispredict;
   logic [31:0] pred_target, redirect_pc;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_fun3;
`ifdef BP_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
`endif

   int checks = 0;
   int errors = 0;

   branch_predict_unit dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_fun3(ex_fun3),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_pred_taken(ex_pred_taken),
      .ex_pred_tgt(ex_pred_tgt), .br_taken(br_taken), .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
      , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: per-slot valid/tag/target and an integer counter 0..3.
   bit          m_valid [64];
   logic [31:0] m_tag   [64];
   logic [31:0] m_tgt   [64];
   int          m_ctr   [64];
   int          m_branches, m_misp;

   logic        exp_pt, exp_br, exp_misp, exp_ctrl;
   logic [31:0] exp_ptg, exp_redir, exp_target, exp_pc;

   function automatic void model_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 1'b0;
         m_ctr[i]   = 1;
      end
      m_branches = 0;
      m_misp     = 0;
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      int i = int'((pc >> 2) % 64);
      return m_valid[i] && (m_tag[i] == (pc >> 8));
   endfunction

   task automatic apply(input logic v, input logic [31:0] pc, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic pt, input logic [31:0] ptg, input logic [31:0] ipc);
      bit tk;
      int i;
      ex_valid = v; ex_pc = pc; ex_opcode = op; ex_fun3 = f3; ex_rs1 = a; ex_rs2 = b;
      ex_imm = imm; ex_pred_taken = pt; ex_pred_tgt = ptg; if_pc = ipc;
      i       = int'((ipc >> 2) % 64);
      exp_pt  = model_hit(ipc) && (m_ctr[i] >= 2);
      exp_ptg = exp_pt ? m_tgt[i] : ipc + 32'd4;
      exp_ctrl = v && (op == 7'h63 || op == 7'h6F || op == 7'h67);
      tk = 1'b1;
      if (op == 7'h63) begin
         case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) <  $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a <  b);
            3'd7: tk = (a >= b);
            default: tk = 1'b0;
         endcase
      end
      exp_br     = exp_ctrl && tk;
      exp_target = (op == 7'h67) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
      exp_misp   = v && ((exp_br != pt) || (exp_br && (ptg != exp_target)));
      exp_redir  = !v ? 32'd0 : (exp_br ? exp_target : pc + 32'd4);
      exp_pc     = pc;
      #4;
   endtask

   task automatic commit();
      int i;
      @(posedge clk);
      i = int'((exp_pc >> 2) % 64);
      if (exp_ctrl) begin
         m_branches++;
         if (exp_br) begin
            m_ctr[i]   = model_hit(exp_pc) ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : 2;
            m_valid[i] = 1'b1;
            m_tag[i]   = exp_pc >> 8;
            m_tgt[i]   = exp_target;
         end else begin
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
         end
      end
      if (exp_misp) m_misp++;
      #1;
   endtask

   task automatic idle(input logic [31:0] ipc);
      apply(1'b0, 32'h0, 7'h13, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, ipc);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; model_reset();
      ex_valid = 1'b0; ex_pc = 32'h0; ex_opcode = 7'h6F; ex_fun3 = 3'd0; ex_rs1 = 32'h0; ex_rs2 = 32'h0;
      ex_imm = 32'h40; ex_pred_taken = 1'b1; ex_pred_tgt = 32'h0; if_pc = 32'h100;
      #3;
      checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
      checks++; if (pred_target !== 32'h104) begin errors++; $display("FAIL reset_pred_target: got %h want 00000104", pred_target); end
      checks++; if (br_taken !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 32'h0) begin
         errors++; $display("FAIL ex_invalid_outputs: got %b/%b/%h want 0/0/0", br_taken, mispredict, redirect_pc); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
`ifdef BP_STATS_EN
      checks++; if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
         errors++; $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts); end
`endif
   endtask

   task automatic test_beq();
      do_reset();
      apply(1'b1, 32'h100, 7'h63, 3'd0, 32'd5, 32'd5, 32'h20, 1'b0, 32'h104, 32'h100);
      checks++; if (br_taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", br_taken); end
      checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL beq_mispredict: got %b want 1", mispredict); end
      checks++; if (redirect_pc !== 32'h120) begin errors++; $display("FAIL beq_redirect: got %h want 00000120", redirect_pc); end
      commit();
      idle(32'h100);
      checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h120) begin
         errors++; $display("FAIL beq_trained_pred: got %b/%h want 1/00000120", pred_taken, pred_target); end
      commit();
   endtask

   task automatic test_cond();
      apply(1'b1, 32'h400, 7'h63, 3'd5, 32'h8000_0000, 32'd1, 32'h40, 1'b0, 32'h404, 32'h0);
      checks++; if (br_taken !== 1'b0 || mispredict !== 1'b0 || redirect_pc !== 32'h404) begin
         errors++; $display("FAIL bge_signed: got %b/%b/%h want 0/0/00000404", br_taken, mispredict, redirect_pc); end
      commit();
      apply(1'b1, 32'h400, 7'h63, 3'd7, 32'h8000_0000, 32'd1, 32'h40, 1'b0, 32'h404, 32'h0);
      checks++; if (br_taken !== 1'b1 || redirect_pc !== 32'h440) begin
         errors++; $display("FAIL bgeu_unsigned: got %b/%h want 1/00000440", br_taken, redirect_pc); end
      commit();
      apply(1'b1, 32'h500, 7'h63, 3'd5, 32'h1234, 32'h1234, 32'h8, 1'b1, 32'h508, 32'h0);
      checks++; if (br_taken !== 1'b1 || mispredict !== 1'b0) begin
         errors++; $display("FAIL bge_equal: got %b/%b want 1/0", br_taken, mispredict); end
      commit();
      apply(1'b1, 32'h600, 7'h63, 3'd2, 32'h1, 32'h1, 32'h8, 1'b0, 32'h604, 32'h0);
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL fun3_010_not_taken: got %b want 0", br_taken); end
      commit();
      apply(1'b1, 32'h700, 7'h33, 3'd0, 32'h1, 32'h1, 32'h8, 1'b1, 32'h900, 32'h0);
      checks++; if (br_taken !== 1'b0 || mispredict !== 1'b1 || redirect_pc !== 32'h704) begin
         errors++; $display("FAIL nonctrl_pred_taken: got %b/%b/%h want 0/1/00000704", br_taken, mispredict, redirect_pc); end
      commit();
   endtask

   task automatic test_jalr();
      apply(1'b1, 32'h800, 7'h67, 3'd0, 32'h203, 32'h0, 32'h0, 1'b1, 32'h200, 32'h0);
      checks++; if (br_taken !== 1'b1 || mispredict !== 1'b1 || redirect_pc !== 32'h202) begin
         errors++; $display("FAIL jalr_bad_tgt: got %b/%b/%h want 1/1/00000202", br_taken, mispredict, redirect_pc); end
      commit();
      apply(1'b1, 32'h800, 7'h67, 3'd0, 32'h203, 32'h0, 32'h0, 1'b1, 32'h202, 32'h800);
      checks++; if (mispredict !== 1'b0 || pred_taken !== 1'b1 || pred_target !== 32'h202) begin
         errors++; $display("FAIL jalr_good_tgt: got %b/%b/%h want 0/1/00000202", mispredict, pred_taken, pred_target); end
      commit();
   endtask

   task automatic test_training();
      do_reset();
      repeat (4) begin
         apply(1'b1, 32'h100, 7'h63, 3'd0, 32'd1, 32'd1, 32'h20, 1'b0, 32'h0, 32'h100);
         commit();
      end
      apply(1'b1, 32'h100, 7'h63, 3'd1, 32'd1, 32'd1, 32'h20, 1'b1, 32'h120, 32'h100);
      checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_saturated: got %b want 1", pred_taken); end
      commit();
      idle(32'h100);
      checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h120) begin
         errors++; $display("FAIL train_one_nt: got %b/%h want 1/00000120", pred_taken, pred_target); end
      apply(1'b1, 32'h100, 7'h63, 3'd1, 32'd1, 32'd1, 32'h20, 1'b1, 32'h120, 32'h100);
      commit();
      idle(32'h100);
      checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         errors++; $display("FAIL train_two_nt: got %b/%h want 0/00000104", pred_taken, pred_target); end
      commit();
      // Retrain then pull reset mid-cycle: prediction must drop immediately.
      repeat (2) begin
         apply(1'b1, 32'h100, 7'h6F, 3'd0, 32'd0, 32'd0, 32'h20, 1'b0, 32'h0, 32'h100);
         commit();
      end
      idle(32'h100);
      rst_n = 1'b0; model_reset();
      #1;
      checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         errors++; $display("FAIL reset_midop: got %b/%h want 0/00000104", pred_taken, pred_target); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_same_cycle();
      do_reset();
      apply(1'b1, 32'h300, 7'h6F, 3'd0, 32'd0, 32'd0, 32'h40, 1'b0, 32'h0, 32'h300);
      checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h304) begin
         errors++; $display("FAIL same_cycle_old: got %b/%h want 0/00000304", pred_taken, pred_target); end
      commit();
      idle(32'h300);
      checks++; if (pred_taken !== 1'b1 || pred_target !== 32'h340) begin
         errors++; $display("FAIL same_cycle_new: got %b/%h want 1/00000340", pred_taken, pred_target); end
      commit();
   endtask

   task automatic test_random();
      logic [31:0] pcs [8] = '{32'h100, 32'h104, 32'h1100, 32'h200, 32'h3FC, 32'h8000_0100, 32'h8000_0104, 32'h240};
      logic [31:0] vals [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h5};
      logic [6:0]  ops [5] = '{7'h63, 7'h63, 7'h6F, 7'h67, 7'h33};
      do_reset();
      for (int n = 0; n < 400; n++) begin
         logic [31:0] epc, ipc, a, b, imm, ptg;
         logic        pt, v;
         int          j;
         epc = pcs[$urandom_range(0, 7)];
         ipc = pcs[$urandom_range(0, 7)];
         a   = ($urandom_range(0, 3) == 0) ? $urandom : vals[$urandom_range(0, 5)];
         b   = ($urandom_range(0, 3) == 0) ? $urandom : vals[$urandom_range(0, 5)];
         imm = ($urandom & 32'h1FC) - 32'h100;
         v   = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 1) == 0) begin
            j   = int'((epc >> 2) % 64);
            pt  = model_hit(epc) && (m_ctr[j] >= 2);
            ptg = pt ? m_tgt[j] : epc + 32'd4;
         end else begin
            pt  = 1'($urandom);
            ptg = pcs[$urandom_range(0, 7)];
         end
         apply(v, epc, ops[$urandom_range(0, 4)], 3'($urandom), a, b, imm, pt, ptg, ipc);
         checks++; if (pred_taken !== exp_pt) begin errors++; $display("FAIL rnd_pred_taken[%0d]: got %b want %b", n, pred_taken, exp_pt); end
         checks++; if (pred_target !== exp_ptg) begin errors++; $display("FAIL rnd_pred_target[%0d]: got %h want %h", n, pred_target, exp_ptg); end
         checks++; if (br_taken !== exp_br) begin errors++; $display("FAIL rnd_br_taken[%0d]: got %b want %b", n, br_taken, exp_br); end
         checks++; if (mispredict !== exp_misp) begin errors++; $display("FAIL rnd_mispredict[%0d]: got %b want %b", n, mispredict, exp_misp); end
         checks++; if (redirect_pc !== exp_redir) begin errors++; $display("FAIL rnd_redirect[%0d]: got %h want %h", n, redirect_pc, exp_redir); end
         commit();
      end
`ifdef BP_STATS_EN
      checks++; if (stat_branches !== 32'(m_branches) || stat_mispredicts !== 32'(m_misp)) begin
         errors++; $display("FAIL rnd_stats: got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts, m_branches, m_misp); end
`endif
   endtask

`ifdef BP_STATS_EN
   task automatic test_stats();
      do_reset();
      for (int n = 0; n < 10; n++) begin
         // BEQ always taken to 0x120; predictions for n = 2, 5, 8 are deliberately wrong.
         if (n % 3 == 2)
            apply(1'b1, 32'h100, 7'h63, 3'd0, 32'd7, 32'd7, 32'h20, 1'b0, 32'h104, 32'h0);
         else
            apply(1'b1, 32'h100, 7'h63, 3'd0, 32'd7, 32'd7, 32'h20, 1'b1, 32'h120, 32'h0);
         commit();
      end
      idle(32'h0);
      checks++; if (stat_branches !== 32'd10 || stat_mispredicts !== 32'd3) begin
         errors++; $display("FAIL stats_10_3: got %0d/%0d want 10/3", stat_branches, stat_mispredicts); end
      commit();
   endtask
`endif

   initial begin
      test_reset();
      test_beq();
      test_cond();
      test_jalr();
      test_training();
      test_same_cycle();
`ifdef BP_STATS_EN
      test_stats();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
